// File: rtl/tx_cp_insert_if.sv
// Sample streams around the cyclic-prefix inserter: IFFT samples in, CP-extended bursts out.
interface tx_cp_insert_if #(
  parameter int DW = 12
);
  logic [DW-1:0] di_re;
  logic [DW-1:0] di_im;
  logic          di_vld;
  logic          di_last;
  logic          di_rdy;
  logic [DW-1:0] do_re;
  logic [DW-1:0] do_im;
  logic          do_vld;
  logic          do_sym_start;
  logic          do_last;

  modport master (
    output di_re, di_im, di_vld, di_last,
    input  di_rdy, do_re, do_im, do_vld, do_sym_start, do_last
  );

  modport slave (
    input  di_re, di_im, di_vld, di_last,
    output di_rdy, do_re, do_im, do_vld, do_sym_start, do_last
  );
endinterface

// File: rtl/tx_cp_insert.sv
// Cyclic-prefix inserter: ping-pong buffers IFFT symbols and replays each as CP + body.
module tx_cp_insert #(
  parameter int N_FFT = 64,
  parameter int N_CP  = 16,
  parameter int DW    = 12
) (
  input  logic           clk,
  input  logic           rst,
  tx_cp_insert_if.slave  bus
);

  localparam int AW = $clog2(N_FFT);
  localparam logic [AW-1:0] CP_START = AW'(N_FFT - N_CP);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_FFT - 1);

  typedef enum logic [1:0] {IDLE, CP, BODY} state_t;

  // Both banks share one array; the bank select is the address MSB.
  logic [2*DW-1:0] mem [0:2*N_FFT-1];

  state_t        state, state_nxt;
  logic          rst_q;
  logic          wb, rb, rb_nxt;
  logic [AW-1:0] wc, rc, rc_nxt;
  logic [1:0]    full, full_nxt, last;
  logic          rdy, wr_en, wr_done, rd_en, clr_full;

  assign rdy     = !rst_q && !full[wb];
  assign wr_en   = bus.di_vld && rdy;
  assign wr_done = wr_en && (wc == LAST_IDX);
  assign bus.di_rdy = rdy;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wb, wc}] <= {bus.di_re, bus.di_im};
    end
  end

  // A completing write and a finishing read always target different banks.
  always_comb begin
    full_nxt = full;
    if (clr_full) full_nxt[rb] = 1'b0;
    if (wr_done)  full_nxt[wb] = 1'b1;
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      wb    <= 1'b0;
      wc    <= '0;
      rb    <= 1'b0;
      rc    <= '0;
      full  <= '0;
      last  <= '0;
      state <= IDLE;
    end else begin
      state <= state_nxt;
      rc    <= rc_nxt;
      rb    <= rb_nxt;
      full  <= full_nxt;
      if (wr_done) begin
        wc       <= '0;
        wb       <= ~wb;
        last[wb] <= bus.di_last;
      end else if (wr_en) begin
        wc <= wc + AW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rc_nxt    = rc;
    rb_nxt    = rb;
    rd_en     = 1'b0;
    clr_full  = 1'b0;
    case (state)
      IDLE: begin
        if (full[rb]) begin
          state_nxt = CP;
          rc_nxt    = CP_START;
        end
      end
      CP: begin
        rd_en = 1'b1;
        if (rc == LAST_IDX) begin
          state_nxt = BODY;
          rc_nxt    = '0;
        end else begin
          rc_nxt = rc + AW'(1);
        end
      end
      BODY: begin
        rd_en = 1'b1;
        if (rc == LAST_IDX) begin
          clr_full  = 1'b1;
          rb_nxt    = ~rb;
          rc_nxt    = CP_START;
          state_nxt = full[~rb] ? CP : IDLE;
        end else begin
          rc_nxt = rc + AW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output stage: registered read data, zeroed whenever nothing is being read.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.do_re        <= '0;
      bus.do_im        <= '0;
      bus.do_vld       <= 1'b0;
      bus.do_sym_start <= 1'b0;
      bus.do_last      <= 1'b0;
    end else begin
      bus.do_vld       <= rd_en;
      bus.do_sym_start <= (state == CP) && (rc == CP_START);
      bus.do_last      <= (state == BODY) && (rc == LAST_IDX) && last[rb];
      if (rd_en) begin
        {bus.do_re, bus.do_im} <= mem[{rb, rc}];
      end else begin
        bus.do_re <= '0;
        bus.do_im <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tx_cp_insert.sv
// Bench for tx_cp_insert: symbol-level reference model plus literal checks on ramp symbols.
module tb_tx_cp_insert;

  localparam int N_FFT = 64;
  localparam int N_CP  = 16;
  localparam int DW    = 12;
  localparam int SYM   = N_FFT + N_CP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_cp_insert_if #(.DW(DW)) bus ();

  tx_cp_insert #(.N_FFT(N_FFT), .N_CP(N_CP), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          sym_start;
    logic          last;
    int            edge_no;
  } exp_t;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  exp_t            exp_q[$];
  logic [2*DW-1:0] part_q[$];
  int              finish_q[$];
  int              prev_end = -1000;
  bit              pred_rdy = 1'b0;
  bit              rst_q_m  = 1'b0;

  int  vld_cnt, start_cnt, last_cnt, rise_cnt, stall_cnt;
  bit  prev_vld;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a completed symbol starts 2 edges after completion, or right after the previous burst.
  always @(posedge clk) begin
    bit              acc;
    int              start;
    int              idx;
    logic [2*DW-1:0] w;
    exp_t            e;
    cyc = cyc + 1;
    acc = !rst && bus.di_vld && pred_rdy;
    if (rst) begin
      exp_q.delete();
      part_q.delete();
      finish_q.delete();
      prev_end = -1000;
    end else if (acc) begin
      part_q.push_back({bus.di_re, bus.di_im});
      if (part_q.size() == N_FFT) begin
        start = (cyc + 2 > prev_end + 1) ? cyc + 2 : prev_end + 1;
        for (int j = 0; j < SYM; j++) begin
          idx         = (j < N_CP) ? (N_FFT - N_CP + j) : (j - N_CP);
          w           = part_q[idx];
          e.re        = w[2*DW-1:DW];
          e.im        = w[DW-1:0];
          e.sym_start = (j == 0);
          e.last      = (j == SYM - 1) && bus.di_last;
          e.edge_no   = start + j;
          exp_q.push_back(e);
        end
        prev_end = start + SYM - 1;
        finish_q.push_back(prev_end);
        part_q.delete();
      end
    end
    rst_q_m = rst;
    while (finish_q.size() > 0 && finish_q[0] <= cyc) void'(finish_q.pop_front());
    pred_rdy = !rst_q_m && (finish_q.size() < 2);
  end

  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (cyc > 0) begin
      have = (exp_q.size() > 0) && (exp_q[0].edge_no == cyc);
      if (have) begin
        e = exp_q.pop_front();
      end else begin
        e.re = '0; e.im = '0; e.sym_start = 1'b0; e.last = 1'b0; e.edge_no = cyc;
      end
      checkOutput("do_vld",       bus.do_vld,       have);
      checkOutput("do_re",        bus.do_re,        e.re);
      checkOutput("do_im",        bus.do_im,        e.im);
      checkOutput("do_sym_start", bus.do_sym_start, e.sym_start);
      checkOutput("do_last",      bus.do_last,      e.last);
      checkOutput("di_rdy",       bus.di_rdy,       pred_rdy);
      if (bus.do_vld === 1'b1) vld_cnt++;
      if (bus.do_sym_start === 1'b1) start_cnt++;
      if (bus.do_last === 1'b1) last_cnt++;
      if (bus.do_vld === 1'b1 && !prev_vld) rise_cnt++;
      if (bus.di_vld && bus.di_rdy === 1'b0) stall_cnt++;
      prev_vld = (bus.do_vld === 1'b1);
    end
  end

  task automatic clearCounters();
    vld_cnt = 0; start_cnt = 0; last_cnt = 0; rise_cnt = 0; stall_cnt = 0;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic lastf);
    bit ok;
    int n;
    n = 0;
    bus.di_re = re; bus.di_im = im; bus.di_last = lastf; bus.di_vld = 1'b1;
    do begin
      @(negedge clk);
      ok = (bus.di_rdy === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 2000);
    if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idleCycles(input int n);
    bus.di_vld = 1'b0;
    bus.di_last = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic waitEdge(input int e);
    while (cyc < e) begin @(posedge clk); #1; end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.di_vld = 1'b0;
    while (exp_q.size() > 0 && n < 5000) begin @(posedge clk); #1; n++; end
    if (exp_q.size() > 0) checkOutput("drain_timeout", 32'd0, 32'd1);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic applyReset(input int n);
    bus.di_vld = 1'b0;
    rst = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Ramp symbol re=k, im=-k; hand-computed expectations pin the CP ordering and latency.
  task automatic runRamp(input string tag, input bit early_last);
    int t;
    clearCounters();
    for (int k = 0; k < N_FFT; k++)
      applyStimulus(DW'(k), DW'(-k), early_last ? (k == 10) : (k == N_FFT - 1));
    bus.di_vld = 1'b0;
    t = cyc;
    waitEdge(t + 1);
    checkOutput({tag, "_lat1_vld"}, bus.do_vld, 0);
    waitEdge(t + 2);
    checkOutput({tag, "_first_vld"},   bus.do_vld, 1);
    checkOutput({tag, "_first_start"}, bus.do_sym_start, 1);
    checkOutput({tag, "_first_re"},    bus.do_re, 12'd48);
    checkOutput({tag, "_first_im"},    bus.do_im, 12'hFD0);
    waitEdge(t + 18);
    checkOutput({tag, "_body0_re"},    bus.do_re, 12'd0);
    checkOutput({tag, "_body0_start"}, bus.do_sym_start, 0);
    waitEdge(t + 81);
    checkOutput({tag, "_final_re"},    bus.do_re, 12'd63);
    checkOutput({tag, "_final_im"},    bus.do_im, 12'hFC1);
    checkOutput({tag, "_final_last"},  bus.do_last, !early_last);
    waitEdge(t + 82);
    checkOutput({tag, "_after_vld"},   bus.do_vld, 0);
    drain();
    checkOutput({tag, "_burst_len"},   vld_cnt, 80);
    checkOutput({tag, "_start_cnt"},   start_cnt, 1);
    checkOutput({tag, "_last_cnt"},    last_cnt, early_last ? 0 : 1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.di_re = '0; bus.di_im = '0; bus.di_vld = 1'b0; bus.di_last = 1'b0;
    prev_vld = 1'b0;
    clearCounters();

    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_di_rdy", bus.di_rdy, 0);
    checkOutput("rst_do_vld", bus.do_vld, 0);
    @(posedge clk); #1;
    applyReset(1);
    @(negedge clk);
    checkOutput("post_rst_rdy", bus.di_rdy, 1);
    @(posedge clk); #1;

    runRamp("ramp", 1'b0);

    // Long continuous frame; only the final symbol carries di_last.
    clearCounters();
    for (int s = 0; s < 107; s++)
      for (int k = 0; k < N_FFT; k++)
        applyStimulus(DW'($urandom), DW'($urandom), (s == 106) && (k == N_FFT - 1));
    drain();
    checkOutput("b2b_samples", vld_cnt, 8560);
    checkOutput("b2b_starts",  start_cnt, 107);
    checkOutput("b2b_bursts",  rise_cnt, 1);
    checkOutput("b2b_lasts",   last_cnt, 1);

    // Valid held high regardless of ready; refused samples are simply lost.
    applyReset(2);
    clearCounters();
    for (int i = 0; i < 300; i++) begin
      bus.di_re = DW'($urandom); bus.di_im = DW'($urandom);
      bus.di_last = 1'($urandom); bus.di_vld = 1'b1;
      @(posedge clk); #1;
    end
    drain();
    checkOutput("bp_stalled", stall_cnt > 0, 1);

    applyReset(1);
    clearCounters();
    for (int k = 0; k < 40; k++) applyStimulus(DW'($urandom), DW'($urandom), 1'b0);
    idleCycles(200);
    checkOutput("partial_no_out", vld_cnt, 0);
    for (int k = 0; k < 24; k++) applyStimulus(DW'($urandom), DW'($urandom), k == 23);
    drain();
    checkOutput("partial_burst", vld_cnt, 80);
    checkOutput("partial_rises", rise_cnt, 1);

    // Reset lands mid-burst while the next symbol is being written.
    applyReset(1);
    for (int k = 0; k < N_FFT + 29; k++) applyStimulus(DW'($urandom), DW'($urandom), 1'b1);
    bus.di_vld = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_busy_vld", bus.do_vld, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_vld", bus.do_vld, 0);
    checkOutput("mid_rst_re",  bus.do_re, 0);
    checkOutput("mid_rst_rdy", bus.di_rdy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("mid_rst_rdy_back", bus.di_rdy, 1);
    @(posedge clk); #1;
    runRamp("fresh", 1'b0);

    runRamp("early_last", 1'b1);

    // Random data, random gaps and stray di_last pulses.
    applyReset(1);
    for (int s = 0; s < 8; s++)
      for (int k = 0; k < N_FFT; k++) begin
        applyStimulus(DW'($urandom), DW'($urandom), 1'($urandom));
        idleCycles($urandom_range(0, 3));
      end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
